// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32x32 multiply / divide unit with HI/LO result registers
// Optional divider: define MDU_DIV_EN to build DIV/DIVU; otherwise divide requests complete as no-ops.
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic        r_op_div;
  logic [31:0] r_a;
  logic [63:0] r_acc;
  logic        r_neg_res;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [32:0] w_msum;
  logic        w_write;

  // op_i[0]=0 selects the signed flavour of both MULT and DIV
  assign w_signed = ~op_i[0];
  assign w_rs_mag = (w_signed && RSdata_i[31]) ? -RSdata_i : RSdata_i;
  assign w_rt_mag = (w_signed && RTdata_i[31]) ? -RTdata_i : RTdata_i;

  // shift-add step: multiplier sits in r_acc[31:0], partial product grows from the top
  assign w_msum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);

`ifdef MDU_DIV_EN
  logic [31:0] r_b;
  logic        r_neg_rem;
  logic [32:0] w_dshift;
  logic [32:0] w_ddiff;
  logic        w_dge;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // restoring step: r_acc holds {partial remainder, remaining dividend bits / quotient bits}
  assign w_dshift  = r_acc[63:31];
  assign w_ddiff   = w_dshift - {1'b0, r_b};
  assign w_dge     = (w_dshift >= {1'b0, r_b});
  assign w_quo_fix = r_neg_res ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem_fix = r_neg_rem ? -r_acc[63:32] : r_acc[63:32];
  assign w_write   = 1'b1;
`else
  // without the divider a divide request must leave HI/LO untouched
  assign w_write   = ~r_op_div;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
`ifdef MDU_DIV_EN
          w_next = CALC;
`else
          w_next = op_i[1] ? DONE : CALC;
`endif
        end
      end
      CALC:    if (r_cnt == 5'd31) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // operand capture, iteration and sign fix-up
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= 5'd0;
      r_op_div  <= 1'b0;
      r_a       <= 32'd0;
      r_acc     <= 64'd0;
      r_neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      r_b       <= 32'd0;
      r_neg_rem <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cnt     <= 5'd0;
            r_op_div  <= op_i[1];
            r_neg_res <= w_signed & (RSdata_i[31] ^ RTdata_i[31]);
            if (!op_i[1]) begin
              r_a   <= w_rs_mag;
              r_acc <= {32'd0, w_rt_mag};
            end
`ifdef MDU_DIV_EN
            else begin
              r_a       <= RSdata_i;
              r_b       <= w_rt_mag;
              r_acc     <= {32'd0, w_rs_mag};
              r_neg_rem <= w_signed & RSdata_i[31];
            end
`endif
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (!r_op_div) begin
            r_acc <= {w_msum, r_acc[31:1]};
          end
`ifdef MDU_DIV_EN
          else if (w_dge) begin
            r_acc <= {w_ddiff[31:0], r_acc[30:0], 1'b1};
          end else begin
            r_acc <= {r_acc[62:0], 1'b0};
          end
`endif
        end
        FIX: begin
          if (!r_op_div) begin
            if (r_neg_res) r_acc <= -r_acc;
          end
`ifdef MDU_DIV_EN
          else if (r_b == 32'd0) begin
            r_acc <= {r_a, 32'hFFFF_FFFF};
          end else begin
            r_acc <= {w_rem_fix, w_quo_fix};
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // result registers and completion pulse, updated only when leaving DONE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_done <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE && w_write) begin
        r_hi <= r_acc[63:32];
        r_lo <= r_acc[31:0];
      end
    end
  end

  assign busy_o = (r_state != IDLE);
  assign done_o = r_done;
  assign HI_o   = r_hi;
  assign LO_o   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - vector, random and corner-sequence bench for mul_div_unit
module tb_mul_div_unit;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .RSdata_i (rs),
    .RTdata_i (rt),
    .busy_o   (busy),
    .done_o   (done),
    .HI_o     (hi),
    .LO_o     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Architectural result of one operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb, q, r;
    logic [63:0] p;
    model = prev;
    case (o)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        model = p;
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        model = p;
      end
      default: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            model = {a, 32'hFFFF_FFFF};
          end else begin
            if (o == 2'd2) begin
              sa = longint'($signed(a));
              sb = longint'($signed(b));
            end else begin
              sa = longint'({32'd0, a});
              sb = longint'({32'd0, b});
            end
            q = sa / sb;
            r = sa % sb;
            model = {r[31:0], q[31:0]};
          end
        end
      end
    endcase
  endfunction

  task automatic exec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int bc);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat, bc, exp_lat;
    exp_lat = (o[1] && !DIV_EN) ? 1 : 34;
    exec(o, a, b, lat, bc);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " busy cycles"}, bc, exp_lat);
    chk({name, " HI"}, hi, eh);
    chk({name, " LO"}, lo, el);
    @(negedge clk);
    chk({name, " done pulse width"}, {31'd0, done}, 32'd0);
    chk({name, " HI hold"}, hi, eh);
    chk({name, " LO hold"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    vec_t tbl[$];
    logic [63:0] e;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int k, ndone;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; rs = 32'd0; rt = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset HI", hi, 32'd0);
    chk("reset LO", lo, 32'd0);
    rst_n = 1'b1;

    tbl.push_back('{op: 2'd0, a: 32'hFFFF_FFFD, b: 32'd7,         exp_hi: 32'hFFFF_FFFF, exp_lo: 32'hFFFF_FFEB});
    tbl.push_back('{op: 2'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp_hi: 32'hFFFF_FFFE, exp_lo: 32'h0000_0001});
    tbl.push_back('{op: 2'd0, a: 32'h8000_0000, b: 32'h8000_0000, exp_hi: 32'h4000_0000, exp_lo: 32'h0000_0000});
    tbl.push_back('{op: 2'd0, a: 32'h8000_0000, b: 32'd1,         exp_hi: 32'hFFFF_FFFF, exp_lo: 32'h8000_0000});
    tbl.push_back('{op: 2'd1, a: 32'd0,         b: 32'h1234_5678, exp_hi: 32'h0000_0000, exp_lo: 32'h0000_0000});
    tbl.push_back('{op: 2'd0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp_hi: 32'h0000_0000, exp_lo: 32'h0000_0001});
`ifdef MDU_DIV_EN
    tbl.push_back('{op: 2'd2, a: 32'hFFFF_FFF9, b: 32'd2,         exp_hi: 32'hFFFF_FFFF, exp_lo: 32'hFFFF_FFFD});
    tbl.push_back('{op: 2'd3, a: 32'd100,       b: 32'd0,         exp_hi: 32'h0000_0064, exp_lo: 32'hFFFF_FFFF});
    tbl.push_back('{op: 2'd2, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp_hi: 32'h0000_0000, exp_lo: 32'h8000_0000});
    tbl.push_back('{op: 2'd2, a: 32'hFFFF_FFF9, b: 32'd0,         exp_hi: 32'hFFFF_FFF9, exp_lo: 32'hFFFF_FFFF});
    tbl.push_back('{op: 2'd3, a: 32'hFFFF_FFFF, b: 32'd10,        exp_hi: 32'h0000_0005, exp_lo: 32'h1999_9999});
    tbl.push_back('{op: 2'd2, a: 32'd7,         b: 32'hFFFF_FFFE, exp_hi: 32'h0000_0001, exp_lo: 32'hFFFF_FFFD});
`endif
    for (int i = 0; i < tbl.size(); i++)
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 1) rb = 32'd0;
      if (i % 5 == 2) rb = 32'($urandom_range(1, 20));
      e = model(ro, ra, rb, {m_hi, m_lo});
      check_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, e[63:32], e[31:0]);
    end

    // divide request with HI=LO=1 preloaded (641 * 6700417 = 2^32 + 1)
    check_op("preload", 2'd1, 32'd641, 32'd6700417, 32'd1, 32'd1);
    e = model(2'd3, 32'd9, 32'd3, {m_hi, m_lo});
    check_op("divu 9/3", 2'd3, 32'd9, 32'd3, e[63:32], e[31:0]);

    // second start pulse mid-operation is ignored
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs = 32'd5; rt = 32'd6;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      if (k == 10) begin start = 1'b1; op = 2'd0; rs = 32'd9; rt = 32'd9; end
      else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("ignored start latency", k, 34);
    chk("ignored start HI", hi, 32'd0);
    chk("ignored start LO", lo, 32'd30);

    // start held high through DONE is only taken in the following IDLE cycle
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs = 32'd3; rt = 32'd4;
    @(negedge clk);
    k = 0;
    while (!done && k < 200) begin
      if (k == 20) begin rs = 32'd5; rt = 32'd5; end
      @(negedge clk);
      k++;
    end
    chk("held start first latency", k, 34);
    chk("held start first LO", lo, 32'd12);
    chk("held start idle gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    k++;
    chk("held start reaccepted", {31'd0, busy}, 32'd1);
    start = 1'b0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("held start second done", k, 69);
    chk("held start second HI", hi, 32'd0);
    chk("held start second LO", lo, 32'd25);

    // reset in the middle of a multiply aborts it
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs = 32'd7; rt = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort HI", hi, 32'd0);
    chk("abort LO", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done pulse", ndone, 0);
    chk("abort LO after wait", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_op("post-reset multu", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
